store_align_buffer: RTL
=======================

// Module: store_align_buffer
// PURPOSE
//   Store path between the MEM stage and data memory: aligns SB/SH/SW data to byte lanes,
//   builds byte enables, splits misaligned stores into two word beats, and queues them in a
//   DEPTH-entry FIFO drained by a valid/ready memory port. Exposes a word-address hazard
//   probe so loads can stall on pending stores.
// PARAMETERS
//   DEPTH      4  FIFO entries; power of two, >=2
//   ADDR_W     32 byte-address width
//   SPLIT_MIS  1  1: split misaligned stores into 2 beats; 0: reject with misalign_fault
// PORTS
//   clk            in   1       single clock, rising edge
//   reset          in   1       synchronous, active-high
//   st_valid       in   1       store request from MEM stage
//   st_ready       out  1       request accepted this cycle when st_valid&&st_ready
//   StoreType      in   2       00 none, 01 SB, 10 SH, 11 SW
//   st_addr        in   ADDR_W  byte address
//   WriteData      in   32      unaligned store data (LSBs significant)
//   misalign_fault out  1       1-cycle pulse: misaligned store rejected (SPLIT_MIS=0)
//   mem_valid      out  1       head entry valid
//   mem_ready      in   1       memory accepts head beat
//   mem_addr       out  ADDR_W  word-aligned address (addr[1:0]=0)
//   mem_wdata      out  32      lane-aligned data, unused lanes 0
//   mem_be         out  4       byte enables
//   ld_addr        in   ADDR_W  load address probe
//   ld_hazard      out  1       comb: a valid entry matches ld_addr[ADDR_W-1:2]
//   empty          out  1       no pending entries
// BEHAVIOUR
//   Reset: count=0, rd/wr ptrs=0, mem_valid=0, misalign_fault=0, empty=1, st_ready=1,
//     ld_hazard=0; entries' data/addr don't-care. Reset mid-operation drops all entries.
//   Alignment: o=st_addr[1:0]; m=0001(SB)/0011(SH)/1111(SW); d masked to size;
//     be8=m<<o (8 bits), d64={32'b0,d}<<(8*o). Beat0: addr word W, be8[3:0], d64[31:0].
//     Beat1 (needed iff be8[7:4]!=0): word W+4 (wraps mod 2^ADDR_W), be8[7:4], d64[63:32].
//   Accept: need=2 if beat1 needed and SPLIT_MIS=1, else 1. st_ready=(DEPTH-count)>=need,
//     from registered count only; a same-cycle dequeue does not raise st_ready.
//   StoreType=00 with st_valid: st_ready=1, consumed, no enqueue.
//   SPLIT_MIS=0 and beat1 needed: st_ready=1, consumed, no enqueue, misalign_fault=1 next cycle.
//   Enqueue on st_valid&&st_ready: beat0 at wr_ptr, beat1 at wr_ptr+1; ptrs wrap mod DEPTH.
//   Dequeue on mem_valid&&mem_ready: rd_ptr++; mem_* outputs driven from head entry (FIFO
//     registers, no comb path from st_* to mem_*); first beat visible 1 cycle after accept.
//   Beats of a split store leave back-to-back in order beat0, beat1; never reordered.
//   Simultaneous enq+deq: count += need-1; full FIFO with mem_ready=1 still holds st_ready=0.
//   mem_* stable while mem_valid&&!mem_ready. mem_valid=!empty.
//   ld_hazard: OR over valid entries of (entry word addr == ld_addr word addr); an entry
//     dequeued this cycle still counts; an entry enqueued this cycle does not.
// STRUCTURE
//   Include store_defs.vh: ST_NONE/ST_SB/ST_SH/ST_SW encodings, BE_B/BE_H/BE_W masks.
//   Sub-module store_lane_align (comb): StoreType, addr[1:0], WriteData -> be8, d64, need2.
//   Top: FIFO storage arrays, ptrs, count, hazard compare, fault register.
// TESTING
//   SB addr 0x103, data 0xAB -> one beat: addr 0x100, be 1000, wdata 0xAB000000.
//   SW addr 0x206, data 0x11223344, SPLIT_MIS=1 -> beat0 0x204 be 1100 wdata 0x33440000;
//     beat1 0x208 be 0011 wdata 0x00001122; back-to-back when mem_ready=1.
//   Same SW with SPLIT_MIS=0 -> no enqueue, misalign_fault pulse 1 cycle, empty stays 1.
//   mem_ready=0, 4 SWs (DEPTH=4) -> st_ready=0 on 5th; mem_ready=1 one cycle -> st_ready=1
//     next cycle, not same cycle; data order preserved.
//   Pending SH at 0x40 -> ld_addr 0x42 gives ld_hazard=1, 0x44 gives 0; clears after drain.
//   Reset asserted with 3 entries queued -> next cycle empty=1, mem_valid=0, ld_hazard=0.

Source files
------------

// File: rtl/store_align_buffer_pkg.sv
// Shared store encodings, byte-enable masks and the FIFO beat payload.
package store_align_buffer_pkg;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_SB   = 2'b01;
    localparam logic [1:0] ST_SH   = 2'b10;
    localparam logic [1:0] ST_SW   = 2'b11;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } beat_t;

    function automatic logic [3:0] size_mask(input logic [1:0] store_type);
        case (store_type)
            ST_SB:   return BE_B;
            ST_SH:   return BE_H;
            ST_SW:   return BE_W;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane alignment: shifts sized store data and byte enables across an 8-byte window.
module store_lane_align
    import store_align_buffer_pkg::*;
(
    input  logic [1:0]  store_type,
    input  logic [1:0]  offset,
    input  logic [31:0] write_data,
    output logic [7:0]  be8_c,
    output logic [63:0] d64_c,
    output logic        need2_c
);

    logic [3:0]  mask;
    logic [31:0] data_m;

    always_comb begin
        mask    = size_mask(store_type);
        data_m  = write_data & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        be8_c   = 8'(mask) << offset;
        d64_c   = 64'(data_m) << {offset, 3'b000};
        // Any enable spilling into the upper word means the store crosses a word boundary.
        need2_c = |be8_c[7:4];
    end

endmodule

// File: rtl/store_align_buffer.sv
// Store path FIFO: aligns MEM-stage stores into word beats and queues them for the memory port.
module store_align_buffer
    import store_align_buffer_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter bit          SPLIT_MIS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [1:0]        StoreType,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       WriteData,
    output logic              misalign_fault,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hazard,
    output logic              empty
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned WORD_W = ADDR_W - 2;

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_ptr_nxt;
    logic [CNT_W-1:0]  count_q, count_d, free, need;
    logic              fault_q, fault_d;
    logic [WORD_W-1:0] word_q [DEPTH];
    logic [WORD_W-1:0] word_d [DEPTH];
    beat_t             beat_q [DEPTH];
    beat_t             beat_d [DEPTH];

    logic [7:0]        be8;
    logic [63:0]       d64;
    logic              need2, need_two, mis_reject, is_none, enq, deq;
    logic [WORD_W-1:0] st_word;
    logic [ADDR_W-1:0] ld_word;

    store_lane_align u_align (
        .store_type (StoreType),
        .offset     (st_addr[1:0]),
        .write_data (WriteData),
        .be8_c      (be8),
        .d64_c      (d64),
        .need2_c    (need2)
    );

    // Acceptance uses the registered count only, so a same-cycle dequeue never frees a slot early.
    always_comb begin
        is_none    = (StoreType == ST_NONE);
        need_two   = need2 && SPLIT_MIS;
        mis_reject = need2 && !SPLIT_MIS && !is_none;
        free       = CNT_W'(DEPTH) - count_q;
        need       = need_two ? CNT_W'(2) : CNT_W'(1);
        st_ready   = is_none || mis_reject || (free >= need);
        enq        = st_valid && st_ready && !is_none && !mis_reject;
        deq        = mem_valid && mem_ready;
        st_word    = st_addr[ADDR_W-1:2];
        wr_ptr_nxt = wr_ptr_q + PTR_W'(1);
    end

    // Next-state for pointers, count, fault pulse and FIFO storage.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        fault_d  = st_valid && mis_reject;
        word_d   = word_q;
        beat_d   = beat_q;
        if (enq) begin
            word_d[wr_ptr_q] = st_word;
            beat_d[wr_ptr_q] = '{be: be8[3:0], data: d64[31:0]};
            if (need_two) begin
                word_d[wr_ptr_nxt] = st_word + WORD_W'(1);
                beat_d[wr_ptr_nxt] = '{be: be8[7:4], data: d64[63:32]};
            end
            wr_ptr_d = wr_ptr_q + (need_two ? PTR_W'(2) : PTR_W'(1));
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + (enq ? need : CNT_W'(0)) - (deq ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            fault_q  <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        word_q <= word_d;
        beat_q <= beat_d;
    end

    // Hazard probe: an entry is live when its distance from rd_ptr is below the registered count.
    always_comb begin
        logic [PTR_W-1:0] off;
        off       = '0;
        ld_word   = ld_addr >> 2;
        ld_hazard = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            off = PTR_W'(j) - rd_ptr_q;
            if ((CNT_W'(off) < count_q) && (ADDR_W'(word_q[PTR_W'(j)]) == ld_word)) begin
                ld_hazard = 1'b1;
            end
        end
    end

    always_comb begin
        mem_valid      = (count_q != '0);
        empty          = (count_q == '0);
        mem_addr       = {word_q[rd_ptr_q], 2'b00};
        mem_be         = beat_q[rd_ptr_q].be;
        mem_wdata      = beat_q[rd_ptr_q].data;
        misalign_fault = fault_q;
    end

endmodule
